// File: rtl/utm_next_state.sv
// Next-state table of the universal Turing machine control unit: one-hot state
// x 3-bit symbol -> registered one-hot next state. Optional input checking via UTM_NS_CHECK_EN.
module utm_next_state (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] state_in,
  input  logic       s2,
  input  logic       s1,
  input  logic       s0,
  output logic [7:0] state_out,
  output logic       halted
`ifdef UTM_NS_CHECK_EN
  ,output logic      err
`endif
);

  // Next-state index per [current state][symbol]; the sym=011 entry equals the row (hold).
  localparam logic [2:0] NEXT_TBL [8][8] = '{
    '{3'd1, 3'd2, 3'd0, 3'd0, 3'd3, 3'd0, 3'd4, 3'd7},  // A
    '{3'd2, 3'd1, 3'd3, 3'd1, 3'd0, 3'd5, 3'd1, 3'd7},  // B
    '{3'd3, 3'd4, 3'd2, 3'd2, 3'd6, 3'd2, 3'd0, 3'd7},  // C
    '{3'd4, 3'd3, 3'd5, 3'd3, 3'd1, 3'd6, 3'd3, 3'd7},  // D
    '{3'd5, 3'd0, 3'd4, 3'd4, 3'd2, 3'd4, 3'd7, 3'd1},  // E
    '{3'd6, 3'd5, 3'd1, 3'd5, 3'd4, 3'd3, 3'd5, 3'd7},  // F
    '{3'd7, 3'd6, 3'd2, 3'd6, 3'd5, 3'd1, 3'd6, 3'd0},  // G
    '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7}   // H
  };

  logic [2:0] sym;
  logic [7:0] row_term [8];
  logic [7:0] table_next;
  logic [7:0] state_d, state_q;
  logic       halted_d, halted_q;
  logic       err_d, err_q;

  assign sym = {s2, s1, s0};

  // AND-OR plane: each asserted state bit contributes its row's one-hot target.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_row
      assign row_term[gi] = state_in[gi] ? (8'h01 << NEXT_TBL[gi][sym]) : 8'h00;
    end
  endgenerate

  always_comb begin
    table_next = 8'h00;
    for (int i = 0; i < 8; i++) begin
      table_next = table_next | row_term[i];
    end
  end

  always_comb begin
    state_d = table_next;
    err_d   = 1'b0;
`ifdef UTM_NS_CHECK_EN
    if ((state_in == 8'h00) || ((state_in & (state_in - 8'd1)) != 8'h00) ||
        (sym == 3'b011)) begin
      state_d = 8'h01;
      err_d   = 1'b1;
    end
`endif
    halted_d = (state_d == 8'h80);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= 8'h01;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign state_out = state_q;
  assign halted    = halted_q;
`ifdef UTM_NS_CHECK_EN
  assign err       = err_q;
`else
  // err_q has no observer in this build; keep it referenced so it is not flagged unused.
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_utm_next_state.sv
// Self-checking bench for utm_next_state: directed corner cases plus randomized
// stimulus against a letter-table reference model (handles UTM_NS_CHECK_EN builds too).
module tb_utm_next_state;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] state_in;
  logic       s2, s1, s0;
  logic [7:0] state_out;
  logic       halted;
`ifdef UTM_NS_CHECK_EN
  logic       err;
  localparam bit CHK = 1'b1;
`else
  logic       err;
  localparam bit CHK = 1'b0;
  assign err = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Transition table as written: row = current state, column = symbol, '*' = hold.
  string ROWS [8] = '{"BCA*DAEH", "CBD*AFBH", "DEC*GCAH", "EDF*BGDH",
                      "FAE*CEHB", "GFB*EDFH", "HGC*FBGA", "HHH*HHHH"};

  utm_next_state dut (
    .clk       (clk),
    .reset     (reset),
    .state_in  (state_in),
    .s2        (s2),
    .s1        (s1),
    .s0        (s0),
    .state_out (state_out),
    .halted    (halted)
`ifdef UTM_NS_CHECK_EN
    ,.err      (err)
`endif
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [7:0] st, input logic [2:0] sym,
                                output logic [7:0] es, output logic eh, output logic ee);
    byte c;
    es = 8'h00;
    ee = 1'b0;
    if (CHK && ($countones(st) != 1 || sym == 3'd3)) begin
      es = 8'h01;
      ee = 1'b1;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (st[i]) begin
          c = ROWS[i][int'(sym)];
          if (c == "*") es = es | (8'h01 << i);
          else          es = es | (8'h01 << (c - "A"));
        end
      end
    end
    eh = (es == 8'h80);
  endfunction

  task automatic apply(input logic rst, input logic [7:0] st, input logic [2:0] sym);
    reset = rst;
    state_in = st;
    {s2, s1, s0} = sym;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      apply(1'b1, 8'($urandom), 3'($urandom));
      checks++;
      if (state_out !== 8'h01 || halted !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: state_out=%h halted=%b err=%b expected 01 0 0",
                 k, state_out, halted, err);
      end
    end
  endtask

  task automatic test_table_sweep();
    logic [7:0] es; logic eh, ee;
    for (int r = 0; r < 8; r++) begin
      for (int s = 0; s < 8; s++) begin
        apply(1'b0, 8'h01 << r, 3'(s));
        model(8'h01 << r, 3'(s), es, eh, ee);
        checks++;
        if (state_out !== es || halted !== eh || err !== ee) begin
          errors++;
          $display("FAIL sweep row=%0d sym=%0d: got %h/%b/%b expected %h/%b/%b",
                   r, s, state_out, halted, err, es, eh, ee);
        end
      end
    end
  endtask

  task automatic test_examples();
    apply(1'b0, 8'h01, 3'b100);
    checks++;
    if (state_out !== 8'h08) begin
      errors++; $display("FAIL example A,100: state_out=%h expected 08", state_out);
    end
    apply(1'b0, 8'h10, 3'b111);
    checks++;
    if (state_out !== 8'h02) begin
      errors++; $display("FAIL example E,111: state_out=%h expected 02", state_out);
    end
  endtask

  task automatic test_halt();
    apply(1'b0, 8'h40, 3'b000);
    checks++;
    if (state_out !== 8'h80 || halted !== 1'b1) begin
      errors++;
      $display("FAIL halt G,000: state_out=%h halted=%b expected 80 1", state_out, halted);
    end
    for (int s = 0; s < 8; s++) begin
      if (s == 3) continue;
      apply(1'b0, 8'h80, 3'(s));
      checks++;
      if (state_out !== 8'h80 || halted !== 1'b1) begin
        errors++;
        $display("FAIL halt H,sym=%0d: state_out=%h halted=%b expected 80 1",
                 s, state_out, halted);
      end
    end
  endtask

  task automatic test_undefined_symbol();
    apply(1'b0, 8'h04, 3'b011);
    checks++;
    if (state_out !== (CHK ? 8'h01 : 8'h04) || err !== CHK || halted !== 1'b0) begin
      errors++;
      $display("FAIL undef C,011: state_out=%h err=%b expected %h %b",
               state_out, err, CHK ? 8'h01 : 8'h04, CHK);
    end
  endtask

  task automatic test_non_onehot();
    apply(1'b0, 8'h03, 3'b000);
    checks++;
    if (state_out !== (CHK ? 8'h01 : 8'h06) || err !== CHK) begin
      errors++;
      $display("FAIL multi 03,000: state_out=%h err=%b expected %h %b",
               state_out, err, CHK ? 8'h01 : 8'h06, CHK);
    end
    apply(1'b0, 8'h00, 3'b010);
    checks++;
    if (state_out !== (CHK ? 8'h01 : 8'h00) || halted !== 1'b0 || err !== CHK) begin
      errors++;
      $display("FAIL zero 00,010: state_out=%h halted=%b err=%b expected %h 0 %b",
               state_out, halted, err, CHK ? 8'h01 : 8'h00, CHK);
    end
  endtask

  task automatic test_random();
    logic [7:0] st, es; logic [2:0] sym; logic eh, ee;
    for (int k = 0; k < 300; k++) begin
      st  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (8'h01 << $urandom_range(0, 7));
      sym = 3'($urandom);
      apply(1'b0, st, sym);
      model(st, sym, es, eh, ee);
      checks++;
      if (state_out !== es || halted !== eh || err !== ee) begin
        errors++;
        $display("FAIL random[%0d] st=%h sym=%0d: got %h/%b/%b expected %h/%b/%b",
                 k, st, sym, state_out, halted, err, es, eh, ee);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply(1'b0, 8'h20, 3'b000);
    apply(1'b0, 8'h08, 3'b110);
    apply(1'b1, 8'h02, 3'b101);
    checks++;
    if (state_out !== 8'h01 || halted !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid B,101: state_out=%h halted=%b expected 01 0", state_out, halted);
    end
    apply(1'b0, 8'h02, 3'b101);
    checks++;
    if (state_out !== 8'h20) begin
      errors++;
      $display("FAIL after_reset B,101: state_out=%h expected 20", state_out);
    end
  endtask

  initial begin
    reset = 1'b1;
    state_in = 8'h00;
    {s2, s1, s0} = 3'b000;
    test_reset();
    test_table_sweep();
    test_examples();
    test_halt();
    test_undefined_symbol();
    test_non_onehot();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
